// File: rtl/msk_agc_pkg.sv
// Shared types and constants for the MSK receive AGC: loop states, gain limits
// and step shifts. MSK_AGC_FAST_ATTACK_EN enables saturation-driven fast attack.
package msk_agc_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_HOLD    = 2'd2
    } agc_state_t;

    localparam logic [15:0] GAIN_ONE = 16'd4096;
    localparam logic [15:0] GAIN_MIN = 16'd256;
    localparam logic [15:0] GAIN_MAX = 16'd65535;

    localparam int ACQ_STEP_SHIFT   = 2;
    localparam int TRK_STEP_SHIFT   = 5;
    localparam int FAST_ATTACK_SATS = 16;

    // Proportional gain step, never smaller than one LSB so the loop always moves.
    function automatic logic [15:0] gain_step(input logic [15:0] g, input int sh);
        logic [15:0] d;
        d = g >> sh;
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/msk_agc_scale.sv
// One rail of the AGC datapath: stage 1 registers the signed x unsigned-gain
// product, stage 2 rounds half-up, drops the fraction bits and saturates.
module msk_agc_scale #(
    parameter int WIDTH     = 16,
    parameter int GAIN_FRAC = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic [15:0]      gain,
    output logic [WIDTH-1:0] dout,
    output logic             sat
);

    localparam int PW = WIDTH + 17;
    localparam logic signed [PW-1:0] ROUND_BIAS = {{(PW-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_HI     = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO     = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] din_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_reg;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic [WIDTH-1:0]     dout_reg;
    logic [WIDTH-1:0]     dout_next;
    logic                 sat_reg;
    logic                 sat_next;

    always_comb begin
        din_ext   = PW'($signed(din));
        gain_ext  = $signed(PW'(gain));
        prod_next = din_ext * gain_ext;
    end

    always_comb begin
        rounded   = prod_reg + ROUND_BIAS;
        shifted   = rounded >>> GAIN_FRAC;
        dout_next = shifted[WIDTH-1:0];
        sat_next  = 1'b0;
        if (shifted > SAT_HI) begin
            dout_next = {1'b0, {(WIDTH-1){1'b1}}};
            sat_next  = 1'b1;
        end else if (shifted < SAT_LO) begin
            dout_next = {1'b1, {(WIDTH-1){1'b0}}};
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_reg <= '0;
            dout_reg <= '0;
            sat_reg  <= 1'b0;
        end else begin
            prod_reg <= prod_next;
            dout_reg <= dout_next;
            sat_reg  <= sat_next;
        end
    end

    assign dout = dout_reg;
    assign sat  = sat_reg;

endmodule

// File: rtl/msk_rx_agc.sv
// MSK receive AGC: scales I/Q by a Q4.12 gain, measures windowed mean envelope
// of the output and steers the gain through ACQUIRE/TRACK/HOLD. Optional macro:
// MSK_AGC_FAST_ATTACK_EN (halve gain on the 16th saturated sample of a window).
module msk_rx_agc
    import msk_agc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int WIN_LOG2   = 8,
    parameter int TARGET_MAG = 8192,
    parameter int GAIN_FRAC  = 12,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             in_valid,
    input  logic             freeze,
    output logic [WIDTH-1:0] i_out,
    output logic [WIDTH-1:0] q_out,
    output logic             out_valid,
    output logic [15:0]      gain,
    output logic             locked
);

    localparam int MW = WIDTH + 1;
    localparam int AW = MW + WIN_LOG2;
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [MW-1:0] BAND_LO  = MW'(TARGET_MAG - TARGET_MAG / 8);
    localparam logic [MW-1:0] BAND_HI  = MW'(TARGET_MAG + TARGET_MAG / 8);
    localparam logic [MW-1:0] FAR_HI   = MW'(2 * TARGET_MAG);
    localparam logic [MW-1:0] FAR_LO   = MW'(TARGET_MAG / 2);
    localparam logic [LW-1:0] LOCK_TGT = LW'(LOCK_CNT);

    logic [1:0][WIDTH-1:0] rail_in;
    logic [1:0][WIDTH-1:0] rail_out;
    logic [1:0][MW-1:0]    rail_abs;
    logic [1:0]            rail_sat;

    logic             v1_reg;
    logic             out_valid_reg;
    logic [15:0]      gain_reg, gain_next;
    logic [AW-1:0]    acc_reg, acc_next, acc_sum;
    logic [WIN_LOG2-1:0] cnt_reg, cnt_next;
    agc_state_t       state_reg, state_next;
    agc_state_t       saved_reg, saved_next;
    logic [LW-1:0]    lock_cnt_reg, lock_cnt_next;

    logic [MW-1:0]    mag_max, mag_min, mag, mean;
    logic [15:0]      delta, gain_up, gain_dn, gain_half;
    logic [16:0]      up_sum, dn_diff;
    logic             in_band, far_off, win_done, fast_trip;

    assign rail_in = {q_in, i_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rail
            msk_agc_scale #(
                .WIDTH     (WIDTH),
                .GAIN_FRAC (GAIN_FRAC)
            ) u_scale (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (rail_in[gi]),
                .gain    (gain_reg),
                .dout    (rail_out[gi]),
                .sat     (rail_sat[gi])
            );
            // One extra bit so |-32768| is representable.
            assign rail_abs[gi] = rail_out[gi][WIDTH-1] ? (MW'(0) - {1'b1, rail_out[gi]})
                                                        : {1'b0, rail_out[gi]};
        end
    endgenerate

    always_comb begin
        if (rail_abs[0] >= rail_abs[1]) begin
            mag_max = rail_abs[0];
            mag_min = rail_abs[1];
        end else begin
            mag_max = rail_abs[1];
            mag_min = rail_abs[0];
        end
        mag     = mag_max + (mag_min >> 1);
        acc_sum = acc_reg + AW'(mag);
        mean    = acc_sum[AW-1:WIN_LOG2];
        in_band = (mean >= BAND_LO) && (mean <= BAND_HI);
        far_off = (mean > FAR_HI) || (mean < FAR_LO);
    end

    assign win_done = out_valid_reg && !freeze && !fast_trip && (&cnt_reg);

`ifdef MSK_AGC_FAST_ATTACK_EN
    logic [4:0] sat_cnt_reg, sat_cnt_next;
    logic       sat_evt;

    assign sat_evt   = out_valid_reg && (|rail_sat);
    assign fast_trip = !freeze && sat_evt && (sat_cnt_reg == 5'(FAST_ATTACK_SATS - 1));

    always_comb begin
        sat_cnt_next = sat_cnt_reg;
        if (freeze || fast_trip || win_done)
            sat_cnt_next = '0;
        else if (sat_evt)
            sat_cnt_next = sat_cnt_reg + 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sat_cnt_reg <= '0;
        else
            sat_cnt_reg <= sat_cnt_next;
    end
`else
    logic unused_sat;
    assign unused_sat = |rail_sat;
    assign fast_trip  = 1'b0;
`endif

    always_comb begin
        delta     = gain_step(gain_reg, (state_reg == ST_TRACK) ? TRK_STEP_SHIFT : ACQ_STEP_SHIFT);
        up_sum    = {1'b0, gain_reg} + {1'b0, delta};
        dn_diff   = {1'b0, gain_reg} - {1'b0, delta};
        gain_up   = up_sum[16] ? GAIN_MAX : up_sum[15:0];
        gain_dn   = (dn_diff[16] || (dn_diff[15:0] < GAIN_MIN)) ? GAIN_MIN : dn_diff[15:0];
        gain_half = ((gain_reg >> 1) < GAIN_MIN) ? GAIN_MIN : (gain_reg >> 1);
    end

    // Freeze outranks every other event: measurement restarts from empty.
    always_comb begin
        gain_next = gain_reg;
        acc_next  = acc_reg;
        cnt_next  = cnt_reg;
        if (freeze) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (fast_trip) begin
            acc_next  = '0;
            cnt_next  = '0;
            gain_next = gain_half;
        end else if (win_done) begin
            acc_next = '0;
            cnt_next = '0;
            if (mean < BAND_LO)
                gain_next = gain_up;
            else if (mean > BAND_HI)
                gain_next = gain_dn;
        end else if (out_valid_reg) begin
            acc_next = acc_sum;
            cnt_next = cnt_reg + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            gain_reg      <= GAIN_ONE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            v1_reg        <= in_valid;
            out_valid_reg <= v1_reg;
            gain_reg      <= gain_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_ACQUIRE;
            saved_reg    <= ST_ACQUIRE;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            saved_reg    <= saved_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        saved_next    = saved_reg;
        lock_cnt_next = lock_cnt_reg;
        if (freeze) begin
            state_next = ST_HOLD;
            if (state_reg != ST_HOLD)
                saved_next = state_reg;
        end else if (fast_trip) begin
            state_next    = ST_ACQUIRE;
            lock_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: state_next = saved_reg;
                ST_ACQUIRE: begin
                    if (win_done) begin
                        if (in_band) begin
                            lock_cnt_next = lock_cnt_reg + LW'(1);
                            if (lock_cnt_next >= LOCK_TGT)
                                state_next = ST_TRACK;
                        end else begin
                            lock_cnt_next = '0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_done && far_off) begin
                        state_next    = ST_ACQUIRE;
                        lock_cnt_next = '0;
                    end
                end
                default: state_next = ST_ACQUIRE;
            endcase
        end
    end

    always_comb begin
        locked = (state_reg == ST_TRACK);
    end

    assign i_out     = rail_out[0];
    assign q_out     = rail_out[1];
    assign out_valid = out_valid_reg;
    assign gain      = gain_reg;

endmodule
